// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// It does one shift per clock and sits upstream of the multiplexed
// seven-segment driver. The packed BCD result is held stable between
// conversions, so the display never shows intermediate values.
//
// Parameters
//   WIDTH    binary input width (27 bits covers 0..99,999,999)
//   DIGITS   number of BCD digits; bcd_out is 4*DIGITS bits
//
// Ports
//   clock     system clock, rising-edge active
//   reset     asynchronous, active-high
//   start     conversion request; accepted in IDLE or DONE, ignored in SHIFT
//   bin_in    unsigned binary value, captured on an accepted start
//   bcd_out   packed BCD result, digit 0 (units) in [3:0]
//   busy      high while a conversion is in progress
//   done      one-cycle pulse when bcd_out has just been updated
//   overflow  last captured value exceeded 10^DIGITS - 1
//
// Output timing: every output is a register fed from the current state.
// With start sampled at edge E0, busy is high for WIDTH cycles. done and the
// new bcd_out appear after edge E0+WIDTH+1. busy and done are never high
// together, including when start is held high for back-to-back conversions.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
  parameter int WIDTH  = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int BCDW = 4 * DIGITS;
  localparam int CNTW = $clog2(WIDTH + 1);

  // Largest value that fits in DIGITS decimal digits (10^digits - 1).
  function automatic logic [63:0] max_value(input int digits);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < digits; i++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

  // Add 3 to every digit that is 5 or more. Each digit is a separate 4-bit
  // add with no carry between digits.
  function automatic logic [BCDW-1:0] add3_digits(input logic [BCDW-1:0] b);
    logic [BCDW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = b[4*i +: 4];
      end
    end
    return r;
  endfunction

  localparam logic [63:0]     MAX_VAL  = max_value(DIGITS);
  localparam logic [BCDW-1:0] ALL_NINE = {DIGITS{4'd9}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;
  logic [WIDTH-1:0]        bin_r;
  logic [BCDW-1:0]         bcd_r;
  logic [CNTW-1:0]         cnt_r;
  logic                    ovf_pend_r;
  logic                    accept_s;
  logic [63:0]             bin_ext_s;
  logic [BCDW+WIDTH-1:0]   shift_s;
  logic [BCDW-1:0]         bcd_out_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    overflow_r;

  // Next-state logic, the accept qualifier and the combined adjust+shift word.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    bin_ext_s    = 64'(bin_in);
    shift_s      = {add3_digits(bcd_r), bin_r} << 1;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s     = 1'b1;
          next_state_s = ST_SHIFT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // The counter reaches zero on this edge, which is the final shift.
        if (cnt_r == CNTW'(1)) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (start) begin
          accept_s     = 1'b1;
          next_state_s = ST_SHIFT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Working registers: capture on accept, then adjust and shift once per cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bin_r      <= {WIDTH{1'b0}};
      bcd_r      <= {BCDW{1'b0}};
      cnt_r      <= {CNTW{1'b0}};
      ovf_pend_r <= 1'b0;
    end else if (accept_s) begin
      bin_r      <= bin_in;
      bcd_r      <= {BCDW{1'b0}};
      cnt_r      <= CNTW'(WIDTH);
      ovf_pend_r <= (bin_ext_s > MAX_VAL);
    end else if (state_r == ST_SHIFT) begin
      // In the overflow case, bits that leave the top of the BCD word are dropped.
      bcd_r      <= shift_s[BCDW+WIDTH-1:WIDTH];
      bin_r      <= shift_s[WIDTH-1:0];
      cnt_r      <= cnt_r - CNTW'(1);
      ovf_pend_r <= ovf_pend_r;
    end else begin
      bin_r      <= bin_r;
      bcd_r      <= bcd_r;
      cnt_r      <= cnt_r;
      ovf_pend_r <= ovf_pend_r;
    end
  end

  // Registered outputs. The result and overflow update only in DONE, so the
  // display holds its value between conversions.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bcd_out_r  <= {BCDW{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      busy_r <= (state_r == ST_SHIFT);
      done_r <= (state_r == ST_DONE);
      if (state_r == ST_DONE) begin
        bcd_out_r  <= ovf_pend_r ? ALL_NINE : bcd_r;
        overflow_r <= ovf_pend_r;
      end else begin
        bcd_out_r  <= bcd_out_r;
        overflow_r <= overflow_r;
      end
    end
  end

  assign bcd_out  = bcd_out_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq. Expected values come from a
// decimal-arithmetic reference model (divide and modulo by 10).
module tb_bin_to_bcd_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic [26:0] bin_in;
  logic [31:0] bcd_out;
  logic        busy;
  logic        done;
  logic        overflow;

  int n_cmp;
  int n_err;

  bin_to_bcd_seq #(.WIDTH(27), .DIGITS(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .bcd_out  (bcd_out),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: split into decimal digits; out-of-range values show all nines.
  function automatic logic [31:0] ref_bcd(input longint v);
    logic [31:0] r;
    longint      t;
    r = 32'd0;
    if (v > 64'd99999999) return 32'h99999999;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // One conversion with a single-cycle start pulse. bin_in is scrambled
  // mid-conversion, and latency, busy length, result and hold are all checked.
  task automatic convert(input logic [26:0] v, input string tag);
    int          lat;
    int          busy_cnt;
    bit          both;
    logic [31:0] exp_bcd;
    logic        exp_ovf;
    exp_bcd  = ref_bcd(longint'(v));
    exp_ovf  = (longint'(v) > 64'd99999999);
    lat      = 0;
    busy_cnt = 0;
    both     = 1'b0;
    @(negedge clock);
    bin_in = v;
    start  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start  = 1'b0;
    bin_in = 27'($urandom);
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock);
      #1;
      if (busy) busy_cnt++;
      if (busy && done) both = 1'b1;
      if (done) begin
        lat = k;
        break;
      end
    end
    n_cmp++;
    if (lat !== 28) begin
      n_err++;
      $display("FAIL %s latency: got %0d expected 28", tag, lat);
    end
    n_cmp++;
    if (busy_cnt !== 27) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d expected 27", tag, busy_cnt);
    end
    n_cmp++;
    if (both !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy_done_overlap: got 1 expected 0", tag);
    end
    n_cmp++;
    if (bcd_out !== exp_bcd) begin
      n_err++;
      $display("FAIL %s bcd_out: got %h expected %h", tag, bcd_out, exp_bcd);
    end
    n_cmp++;
    if (overflow !== exp_ovf) begin
      n_err++;
      $display("FAIL %s overflow: got %b expected %b", tag, overflow, exp_ovf);
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (done !== 1'b0 || bcd_out !== exp_bcd) begin
      n_err++;
      $display("FAIL %s hold: got done=%b bcd=%h expected done=0 bcd=%h",
               tag, done, bcd_out, exp_bcd);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = 27'd0;
    #22;
    n_cmp++;
    if ({bcd_out, busy, done, overflow} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_state: got bcd=%h busy=%b done=%b ovf=%b expected all 0",
               bcd_out, busy, done, overflow);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    n_cmp++;
    if ({bcd_out, busy, done, overflow} !== 35'd0) begin
      n_err++;
      $display("FAIL post_reset_idle: got bcd=%h busy=%b done=%b expected all 0",
               bcd_out, busy, done);
    end
  endtask

  task automatic test_basic();
    convert(27'd12345678, "basic_12345678");
  endtask

  task automatic test_boundaries();
    convert(27'd0,        "bound_0");
    convert(27'd99999999, "bound_max");
    convert(27'd9,        "bound_9");
    convert(27'd10,       "bound_10");
  endtask

  task automatic test_overflow();
    convert(27'd100000000, "ovf_1e8");
    convert(27'd42,        "after_ovf_42");
    convert(27'h7FFFFFF,   "ovf_allones");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      convert(27'($urandom_range(134217727, 0)), "random");
    end
  endtask

  // A start pulse 5 cycles into a conversion is dropped; bin_in changes too.
  task automatic test_ignore_start();
    int          ndone;
    int          at;
    logic [31:0] last;
    ndone = 0;
    at    = 0;
    last  = 32'd0;
    @(negedge clock);
    bin_in = 27'd1234;
    start  = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clock);
      if (k == 5) begin
        start  = 1'b1;
        bin_in = 27'd5678;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      #1;
      if (done) begin
        ndone++;
        at   = k;
        last = bcd_out;
      end
    end
    n_cmp++;
    if (ndone !== 1) begin
      n_err++;
      $display("FAIL ignore_start_count: got %0d expected 1", ndone);
    end
    n_cmp++;
    if (last !== 32'h00001234 || at !== 28) begin
      n_err++;
      $display("FAIL ignore_start_result: got %h at %0d expected 00001234 at 28",
               last, at);
    end
  endtask

  // start held high: the next value is re-sampled in the DONE cycle.
  task automatic test_back_to_back();
    int          idx[$];
    logic [31:0] val[$];
    bit          busy_ok;
    busy_ok = 1'b1;
    @(negedge clock);
    bin_in = 27'd7;
    start  = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= 56; k++) begin
      @(negedge clock);
      if (k == 1)  bin_in = 27'd8;
      if (k == 29) start  = 1'b0;
      @(posedge clock);
      #1;
      if (busy === done) busy_ok = 1'b0;
      if (done) begin
        idx.push_back(k);
        val.push_back(bcd_out);
      end
    end
    n_cmp++;
    if (idx.size() !== 2) begin
      n_err++;
      $display("FAIL b2b_count: got %0d expected 2", idx.size());
    end else begin
      n_cmp++;
      if (idx[0] !== 28 || idx[1] !== 56) begin
        n_err++;
        $display("FAIL b2b_timing: got %0d,%0d expected 28,56", idx[0], idx[1]);
      end
      n_cmp++;
      if (val[0] !== 32'h00000007 || val[1] !== 32'h00000008) begin
        n_err++;
        $display("FAIL b2b_values: got %h,%h expected 00000007,00000008",
                 val[0], val[1]);
      end
    end
    n_cmp++;
    if (busy_ok !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_busy: got busy not complement of done expected busy=~done");
    end
  endtask

  // Reset asserted mid-cycle aborts a conversion at once; no done follows.
  task automatic test_reset_mid();
    int ndone;
    ndone = 0;
    @(negedge clock);
    bin_in = 27'd12345678;
    start  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bcd_out !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_immediate: got bcd=%h busy=%b done=%b expected 0/0/0",
               bcd_out, busy, done);
    end
    @(negedge clock);
    #2;
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (done) ndone++;
    end
    n_cmp++;
    if (ndone !== 0 || bcd_out !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid_quiet: got done_count=%0d bcd=%h expected 0 and 0",
               ndone, bcd_out);
    end
    convert(27'd87654321, "after_reset_87654321");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_overflow();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
